// File: rtl/ghost_neighbor_fetch.sv
// Ghost neighbour fetch: reads the maze rows above/at/below a ghost tile and derives its four wall flags.
// Optional horizontal tunnel wrap at the maze edges is enabled by defining GHOST_FETCH_WRAP_EN.
module ghost_neighbor_fetch #(
    parameter int COLS    = 32,
    parameter int ROWS    = 32,
    parameter int POS_W   = 10,
    parameter int ROW_AW  = 5,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [POS_W-1:0]  cur_pos,
    output logic              busy,
    output logic              rom_en,
    output logic [ROW_AW-1:0] rom_addr,
    input  logic [COLS-1:0]   rom_data,
    output logic [COLS-1:0]   row_up,
    output logic [COLS-1:0]   row_mid,
    output logic [COLS-1:0]   row_dn,
    output logic [3:0]        walls,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        o_dbg_state
);

    // Output handshake: a result is transferred on a rising edge where out_valid and out_ready
    // are both 1; out_valid and the result stay stable until then and drop on the next cycle.
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [POS_W-1:0]   r_row;
    logic [COL_W-1:0]   r_col;
    logic [1:0]         r_slot;
    logic               r_skip;
    logic [LAT_W-1:0]   r_wait_cnt;
    logic               r_rom_en;
    logic [ROW_AW-1:0]  r_rom_addr;
    logic [COLS-1:0]    r_row_up;
    logic [COLS-1:0]    r_row_mid;
    logic [COLS-1:0]    r_row_dn;
    logic [3:0]         r_walls;
    logic               r_busy;
    logic               r_out_valid;

    logic [POS_W-1:0]   w_start_row;
    logic [COL_W-1:0]   w_start_col;
    logic [POS_W-1:0]   w_issue_row;
    logic [1:0]         w_issue_slot;
    logic [POS_W-1:0]   w_target;
    logic               w_in_range;
    logic [COLS-1:0]    w_cap_word;
    logic               w_edge_left;
    logic               w_edge_right;
    logic               w_left;
    logic               w_right;
    logic [3:0]         w_walls_next;

    assign w_start_row = cur_pos / POS_W'(COLS);
    assign w_start_col = COL_W'(cur_pos % POS_W'(COLS));

    // Target row of the read being issued: row-1+slot. Row 0 minus one wraps to a huge
    // unsigned value, so a single upper-bound compare catches both maze edges.
    assign w_issue_row  = (r_state == S_IDLE) ? w_start_row : r_row;
    assign w_issue_slot = (r_state == S_IDLE) ? 2'd0 : (r_slot + 2'd1);
    assign w_target     = w_issue_row + POS_W'(w_issue_slot) - POS_W'(1);
    assign w_in_range   = (w_target < POS_W'(ROWS));

    assign w_cap_word = r_skip ? {COLS{1'b1}} : rom_data;

`ifdef GHOST_FETCH_WRAP_EN
    assign w_edge_left  = r_row_mid[COLS-1];
    assign w_edge_right = r_row_mid[0];
`else
    assign w_edge_left  = 1'b1;
    assign w_edge_right = 1'b1;
`endif

    assign w_left  = (r_col == '0) ? w_edge_left : r_row_mid[r_col - COL_W'(1)];
    assign w_right = (r_col == COL_W'(COLS-1)) ? w_edge_right : r_row_mid[r_col + COL_W'(1)];
    // Flags are formed on the edge that captures the down row, so that word comes straight from the capture mux.
    assign w_walls_next = {w_right, w_cap_word[r_col], w_left, r_row_up[r_col]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_col       <= '0;
            r_slot      <= '0;
            r_skip      <= 1'b0;
            r_wait_cnt  <= '0;
            r_rom_en    <= 1'b0;
            r_rom_addr  <= '0;
            r_row_up    <= '0;
            r_row_mid   <= '0;
            r_row_dn    <= '0;
            r_walls     <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row      <= w_start_row;
                        r_col      <= w_start_col;
                        r_slot     <= 2'd0;
                        r_busy     <= 1'b1;
                        r_skip     <= !w_in_range;
                        r_rom_en   <= w_in_range;
                        r_rom_addr <= w_in_range ? w_target[ROW_AW-1:0] : '0;
                        r_state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_rom_en   <= 1'b0;
                    r_rom_addr <= '0;
                    r_wait_cnt <= LAT_W'(ROM_LAT - 1);
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        case (r_slot)
                            2'd0:    r_row_up  <= w_cap_word;
                            2'd1:    r_row_mid <= w_cap_word;
                            default: r_row_dn  <= w_cap_word;
                        endcase
                        if (r_slot == 2'd2) begin
                            r_walls     <= w_walls_next;
                            r_busy      <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_slot     <= w_issue_slot;
                            r_skip     <= !w_in_range;
                            r_rom_en   <= w_in_range;
                            r_rom_addr <= w_in_range ? w_target[ROW_AW-1:0] : '0;
                            r_state    <= S_ISSUE;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - LAT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy        = r_busy;
    assign rom_en      = r_rom_en;
    assign rom_addr    = r_rom_addr;
    assign row_up      = r_row_up;
    assign row_mid     = r_row_mid;
    assign row_dn      = r_row_dn;
    assign walls       = r_walls;
    assign out_valid   = r_out_valid;
    assign o_dbg_state = r_state;

endmodule
